// File: rtl/race_logic_pkg.sv
// Shared types and helpers for the race-logic mux slice.
package race_logic_pkg;

    function automatic int value_width(input int gamma);
        return (gamma > 1) ? $clog2(gamma) : 1;
    endfunction

    localparam int GAMMA_CYCLE_WIDTH_DEF = 16;
    localparam int DEF_VALUE_WIDTH       = value_width(GAMMA_CYCLE_WIDTH_DEF);

    typedef logic [DEF_VALUE_WIDTH-1:0] slot_t;

    typedef enum logic {
        WAIT = 1'b0,
        CAPT = 1'b1
    } chan_state_e;

endpackage

// File: rtl/mux_b_t_t_multi_if.sv
// Binary word / temporal select / temporal output bundle for mux_b_t_t_multi.
interface mux_b_t_t_multi_if #(
    parameter int NUM_INPUTS   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int VALUE_WIDTH  = 4
);
    logic [NUM_INPUTS*VALUE_WIDTH-1:0] inputs;
    logic [NUM_CHANNELS-1:0]           select;
    logic [NUM_CHANNELS-1:0]           out;
    logic [NUM_CHANNELS-1:0]           out_null;
    logic                              gamma_start;

    modport master (
        output inputs, select,
        input  out, out_null, gamma_start
    );

    modport slave (
        input  inputs, select,
        output out, out_null, gamma_start
    );
endinterface

// File: rtl/mux_b_t_t_chan.sv
// One channel: earliest-select capture, once-per-cycle word sample, temporal output.
// Pulse-coded output when MUX_B_T_T_PULSE_OUT_EN is defined, step-coded otherwise.
module mux_b_t_t_chan
    import race_logic_pkg::*;
#(
    parameter int PULSE_WIDTH = 8,
    parameter int NUM_INPUTS  = 16,
    parameter int VALUE_WIDTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              live_i,
    input  logic                              boundary_i,
    input  logic [VALUE_WIDTH-1:0]            cur_slot_i,
    input  logic [VALUE_WIDTH-1:0]            nxt_slot_i,
    input  logic [NUM_INPUTS*VALUE_WIDTH-1:0] inputs_i,
    input  logic                              select_i,
    output logic                              out_o,
    output logic                              out_null_o
);
    localparam logic [VALUE_WIDTH:0] NUM_IN_W = (VALUE_WIDTH+1)'(NUM_INPUTS);

    if (PULSE_WIDTH < 1) begin : g_bad_pulse_width
        $error("PULSE_WIDTH must be >= 1");
    end

    chan_state_e            state_q;
    logic [VALUE_WIDTH-1:0] idx_q, emit_val_q, emit_val_d, fin_idx, word_sel;
    logic                   emit_valid_q, emit_valid_d, out_q, out_d, out_null_q;
    logic                   fin_evt, in_range;

    always_comb begin
        // A select first seen in the last slot still counts for this cycle.
        fin_idx  = (state_q == CAPT) ? idx_q : cur_slot_i;
        fin_evt  = (state_q == CAPT) || select_i;
        in_range = ({1'b0, fin_idx} < NUM_IN_W);
        word_sel = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (fin_idx == VALUE_WIDTH'(i)) begin
                word_sel = inputs_i[i*VALUE_WIDTH +: VALUE_WIDTH];
            end
        end

        emit_valid_d = emit_valid_q;
        emit_val_d   = emit_val_q;
        if (boundary_i) begin
            emit_valid_d = fin_evt && in_range;
            emit_val_d   = (fin_evt && in_range) ? word_sel : '0;
        end

        // Output is registered, so it is computed for the slot about to start.
`ifdef MUX_B_T_T_PULSE_OUT_EN
        out_d = emit_valid_d && (nxt_slot_i >= emit_val_d)
                && (32'(nxt_slot_i) < 32'(emit_val_d) + 32'(PULSE_WIDTH));
`else
        out_d = emit_valid_d && (nxt_slot_i >= emit_val_d);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= WAIT;
            idx_q        <= '0;
            emit_valid_q <= 1'b0;
            emit_val_q   <= '0;
            out_q        <= 1'b0;
            out_null_q   <= 1'b1;
        end else begin
            emit_valid_q <= emit_valid_d;
            emit_val_q   <= emit_val_d;
            out_q        <= out_d;
            out_null_q   <= !emit_valid_d;
            if (boundary_i) begin
                state_q <= WAIT;
            end else if (live_i && (state_q == WAIT) && select_i) begin
                state_q <= CAPT;
                idx_q   <= cur_slot_i;
            end
        end
    end

    assign out_o      = out_q;
    assign out_null_o = out_null_q;
endmodule

// File: rtl/mux_b_t_t_multi.sv
// Multi-channel binary-to-temporal race-logic mux with free-running gamma slot counter.
// Optional pulse-coded output via MUX_B_T_T_PULSE_OUT_EN.
module mux_b_t_t_multi
    import race_logic_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = 16,
    parameter int NUM_CHANNELS      = 4
) (
    input  logic               aclk,
    input  logic               grst_n,
    mux_b_t_t_multi_if.slave   bus
);
    localparam int VALUE_WIDTH = value_width(GAMMA_CYCLE_WIDTH);
    localparam logic [VALUE_WIDTH-1:0] LAST_SLOT = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

    if (GAMMA_CYCLE_WIDTH < 2) begin : g_bad_gamma
        $error("GAMMA_CYCLE_WIDTH must be >= 2");
    end
    if (NUM_INPUTS > GAMMA_CYCLE_WIDTH) begin : g_bad_inputs
        $error("NUM_INPUTS must be <= GAMMA_CYCLE_WIDTH");
    end

    // cnt_q runs one slot ahead of slot_q so gamma_start and outputs can be registered.
    logic [VALUE_WIDTH-1:0]  cnt_q, cnt_d, slot_q;
    logic                    live_q, gamma_start_q, boundary;
    logic [NUM_CHANNELS-1:0] out_w, null_w;

    always_comb begin
        cnt_d = (cnt_q == LAST_SLOT) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!grst_n) begin
            cnt_q         <= '0;
            slot_q        <= '0;
            live_q        <= 1'b0;
            gamma_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            slot_q        <= cnt_q;
            live_q        <= 1'b1;
            gamma_start_q <= (cnt_q == '0);
        end
    end

    assign boundary = live_q && (slot_q == LAST_SLOT);

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        mux_b_t_t_chan #(
            .PULSE_WIDTH (PULSE_WIDTH),
            .NUM_INPUTS  (NUM_INPUTS),
            .VALUE_WIDTH (VALUE_WIDTH)
        ) u_chan (
            .clk_i      (aclk),
            .rst_ni     (grst_n),
            .live_i     (live_q),
            .boundary_i (boundary),
            .cur_slot_i (slot_q),
            .nxt_slot_i (cnt_q),
            .inputs_i   (bus.inputs),
            .select_i   (bus.select[ch]),
            .out_o      (out_w[ch]),
            .out_null_o (null_w[ch])
        );
    end

    assign bus.out         = out_w;
    assign bus.out_null    = null_w;
    assign bus.gamma_start = gamma_start_q;
endmodule

// File: tb/tb_mux_b_t_t_multi.sv
// Directed self-checking bench for mux_b_t_t_multi (16-input and 10-input instances).
module tb_mux_b_t_t_multi;
    import race_logic_pkg::*;

    localparam int G  = 16;
    localparam int VW = 4;

    logic aclk   = 1'b0;
    logic grst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   tb_slot = 0;

    mux_b_t_t_multi_if #(.NUM_INPUTS(16), .NUM_CHANNELS(4), .VALUE_WIDTH(VW)) bus16 ();
    mux_b_t_t_multi_if #(.NUM_INPUTS(10), .NUM_CHANNELS(4), .VALUE_WIDTH(VW)) bus10 ();

    mux_b_t_t_multi #(
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (8),
        .NUM_INPUTS        (16),
        .NUM_CHANNELS      (4)
    ) dut16 (
        .aclk   (aclk),
        .grst_n (grst_n),
        .bus    (bus16)
    );

    mux_b_t_t_multi #(
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (8),
        .NUM_INPUTS        (10),
        .NUM_CHANNELS      (4)
    ) dut10 (
        .aclk   (aclk),
        .grst_n (grst_n),
        .bus    (bus10)
    );

    always #5 aclk = ~aclk;

    function automatic logic exp_out(input logic v, input int val, input int s);
`ifdef MUX_B_T_T_PULSE_OUT_EN
        return v && (s >= val) && (s < val + 8);
`else
        return v && (s >= val);
`endif
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
        tb_slot = (tb_slot == G-1) ? 0 : tb_slot + 1;
    endtask

    task automatic goto_slot(input int s);
        while (tb_slot != s) step();
    endtask

    task automatic set_w16(input int i, input int v);
        bus16.inputs[i*VW +: VW] = VW'(v);
    endtask

    task automatic set_w10(input int i, input int v);
        bus10.inputs[i*VW +: VW] = VW'(v);
    endtask

    task automatic test_reset();
        grst_n = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (bus16.out !== 4'h0) begin
                errors++; $display("FAIL rst_out got=%b exp=0000", bus16.out);
            end
            checks++;
            if (bus16.out_null !== 4'hF) begin
                errors++; $display("FAIL rst_null got=%b exp=1111", bus16.out_null);
            end
            checks++;
            if (bus16.gamma_start !== 1'b0) begin
                errors++; $display("FAIL rst_gamma got=%b exp=0", bus16.gamma_start);
            end
        end
        grst_n = 1'b1;
        step();
        tb_slot = 0;
        // two idle cycles: gamma_start cadence and no emission
        for (int i = 0; i < 2*G; i++) begin
            checks++;
            if (bus16.gamma_start !== (tb_slot == 0)) begin
                errors++; $display("FAIL gamma_start slot=%0d got=%b exp=%b",
                                   tb_slot, bus16.gamma_start, tb_slot == 0);
            end
            checks++;
            if (bus16.out !== 4'h0 || bus16.out_null !== 4'hF) begin
                errors++; $display("FAIL idle slot=%0d got out=%b null=%b exp out=0000 null=1111",
                                   tb_slot, bus16.out, bus16.out_null);
            end
            step();
        end
    endtask

    task automatic test_step();
        goto_slot(0);
        set_w16(3, 5);
        goto_slot(3);
        bus16.select[0] = 1'b1;
        step();
        bus16.select[0] = 1'b0;
        goto_slot(0);
        for (int i = 0; i < G; i++) begin
            checks++;
            if (bus16.out[0] !== exp_out(1'b1, 5, tb_slot) || bus16.out_null[0] !== 1'b0) begin
                errors++; $display("FAIL step_ch0 slot=%0d got out=%b null=%b exp out=%b null=0",
                                   tb_slot, bus16.out[0], bus16.out_null[0], exp_out(1'b1, 5, tb_slot));
            end
            checks++;
            if (bus16.out[3:1] !== 3'b000 || bus16.out_null[3:1] !== 3'b111) begin
                errors++; $display("FAIL step_others slot=%0d got out=%b null=%b exp out=000 null=111",
                                   tb_slot, bus16.out[3:1], bus16.out_null[3:1]);
            end
            step();
        end
        for (int i = 0; i < G; i++) begin
            checks++;
            if (bus16.out !== 4'h0 || bus16.out_null !== 4'hF) begin
                errors++; $display("FAIL no_select slot=%0d got out=%b null=%b exp out=0000 null=1111",
                                   tb_slot, bus16.out, bus16.out_null);
            end
            step();
        end
    endtask

    task automatic test_range();
        goto_slot(0);
        set_w16(0, 14);
        set_w16(15, 0);
        set_w10(9, 7);
        bus16.select[3] = 1'b1;
        goto_slot(9);
        bus10.select[1] = 1'b1;
        step();
        bus10.select[1] = 1'b0;
        goto_slot(12);
        bus10.select[0] = 1'b1;
        step();
        bus10.select[0] = 1'b0;
        goto_slot(15);
        bus16.select[0] = 1'b1;
        step();
        bus16.select[0] = 1'b0;
        bus16.select[3] = 1'b0;
        for (int i = 0; i < G; i++) begin
            checks++;
            if (bus10.out[0] !== 1'b0 || bus10.out_null[0] !== 1'b1) begin
                errors++; $display("FAIL out_of_range slot=%0d got out=%b null=%b exp out=0 null=1",
                                   tb_slot, bus10.out[0], bus10.out_null[0]);
            end
            checks++;
            if (bus10.out[1] !== exp_out(1'b1, 7, tb_slot) || bus10.out_null[1] !== 1'b0) begin
                errors++; $display("FAIL last_in_range slot=%0d got out=%b null=%b exp out=%b null=0",
                                   tb_slot, bus10.out[1], bus10.out_null[1], exp_out(1'b1, 7, tb_slot));
            end
            checks++;
            if (bus16.out[0] !== exp_out(1'b1, 0, tb_slot) || bus16.out_null[0] !== 1'b0) begin
                errors++; $display("FAIL last_slot_sel slot=%0d got out=%b null=%b exp out=%b null=0",
                                   tb_slot, bus16.out[0], bus16.out_null[0], exp_out(1'b1, 0, tb_slot));
            end
            checks++;
            if (bus16.out[3] !== exp_out(1'b1, 14, tb_slot) || bus16.out_null[3] !== 1'b0) begin
                errors++; $display("FAIL slot0_sel slot=%0d got out=%b null=%b exp out=%b null=0",
                                   tb_slot, bus16.out[3], bus16.out_null[3], exp_out(1'b1, 14, tb_slot));
            end
            step();
        end
    endtask

    task automatic test_earliest();
        goto_slot(0);
        set_w16(2, 9);
        set_w16(7, 1);
        set_w16(10, 2);
        goto_slot(2);
        bus16.select[1] = 1'b1;
        goto_slot(4);
        bus16.select[1] = 1'b0;
        goto_slot(7);
        bus16.select[1] = 1'b1;
        bus16.select[2] = 1'b1;
        step();
        bus16.select[2] = 1'b0;
        step();
        bus16.select[1] = 1'b0;
        goto_slot(0);
        // emission cycle: also capture ch0 and disturb word2 mid-cycle
        for (int i = 0; i < G; i++) begin
            checks++;
            if (bus16.out[1] !== exp_out(1'b1, 9, tb_slot) || bus16.out_null[1] !== 1'b0) begin
                errors++; $display("FAIL earliest_ch1 slot=%0d got out=%b null=%b exp out=%b null=0",
                                   tb_slot, bus16.out[1], bus16.out_null[1], exp_out(1'b1, 9, tb_slot));
            end
            checks++;
            if (bus16.out[2] !== exp_out(1'b1, 1, tb_slot) || bus16.out_null[2] !== 1'b0) begin
                errors++; $display("FAIL concurrent_ch2 slot=%0d got out=%b null=%b exp out=%b null=0",
                                   tb_slot, bus16.out[2], bus16.out_null[2], exp_out(1'b1, 1, tb_slot));
            end
            checks++;
            if (bus16.out_null[0] !== 1'b1 || bus16.out_null[3] !== 1'b1 || bus16.out[0] !== 1'b0) begin
                errors++; $display("FAIL idle_ch03 slot=%0d got out0=%b null=%b exp out0=0 null0=1 null3=1",
                                   tb_slot, bus16.out[0], bus16.out_null);
            end
            if (tb_slot == 3) set_w16(2, 0);
            bus16.select[0] = (tb_slot == 10);
            step();
        end
        bus16.select[0] = 1'b0;
        for (int i = 0; i < G; i++) begin
            checks++;
            if (bus16.out[0] !== exp_out(1'b1, 2, tb_slot) || bus16.out_null !== 4'b1110) begin
                errors++; $display("FAIL back_to_back slot=%0d got out0=%b null=%b exp out0=%b null=1110",
                                   tb_slot, bus16.out[0], bus16.out_null, exp_out(1'b1, 2, tb_slot));
            end
            step();
        end
    endtask

    task automatic test_pulse_values();
        goto_slot(0);
        set_w16(4, 12);
        set_w16(6, 3);
        goto_slot(4);
        bus16.select[2] = 1'b1;
        step();
        bus16.select[2] = 1'b0;
        goto_slot(6);
        bus16.select[1] = 1'b1;
        step();
        bus16.select[1] = 1'b0;
        goto_slot(0);
        for (int i = 0; i < G; i++) begin
            checks++;
            if (bus16.out[2] !== exp_out(1'b1, 12, tb_slot)) begin
                errors++; $display("FAIL val12_ch2 slot=%0d got=%b exp=%b",
                                   tb_slot, bus16.out[2], exp_out(1'b1, 12, tb_slot));
            end
            checks++;
            if (bus16.out[1] !== exp_out(1'b1, 3, tb_slot)) begin
                errors++; $display("FAIL val3_ch1 slot=%0d got=%b exp=%b",
                                   tb_slot, bus16.out[1], exp_out(1'b1, 3, tb_slot));
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        goto_slot(0);
        set_w16(1, 2);
        goto_slot(1);
        bus16.select[0] = 1'b1;
        step();
        bus16.select[0] = 1'b0;
        goto_slot(0);
        goto_slot(6);
        checks++;
        if (bus16.out[0] !== 1'b1) begin
            errors++; $display("FAIL pre_reset_emit got=%b exp=1", bus16.out[0]);
        end
        grst_n = 1'b0;
        step();
        checks++;
        if (bus16.out !== 4'h0 || bus16.out_null !== 4'hF || bus16.gamma_start !== 1'b0) begin
            errors++; $display("FAIL mid_reset got out=%b null=%b gs=%b exp out=0000 null=1111 gs=0",
                               bus16.out, bus16.out_null, bus16.gamma_start);
        end
        grst_n = 1'b1;
        step();
        tb_slot = 0;
        checks++;
        if (bus16.gamma_start !== 1'b1) begin
            errors++; $display("FAIL post_reset_gamma got=%b exp=1", bus16.gamma_start);
        end
        for (int i = 0; i < G; i++) begin
            checks++;
            if (bus16.out !== 4'h0 || bus16.out_null !== 4'hF) begin
                errors++; $display("FAIL no_resume slot=%0d got out=%b null=%b exp out=0000 null=1111",
                                   tb_slot, bus16.out, bus16.out_null);
            end
            step();
        end
    endtask

    initial begin
        bus16.inputs = '0;
        bus16.select = '0;
        bus10.inputs = '0;
        bus10.select = '0;
        test_reset();
        test_step();
        test_range();
        test_earliest();
        test_pulse_values();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
